// File: rtl/sparce_skip_sequencer_pkg.sv
// Shared types for the SparCE skip sequencer.
// Condition encodings, FSM states and register-index sizing.
package sparce_pkg;

    localparam int REG_W = 5;
    localparam int REG_N = 1 << REG_W;

    typedef enum logic [1:0] {
        RS1_ZERO    = 2'b00,
        RS2_ZERO    = 2'b01,
        EITHER_ZERO = 2'b10,
        BOTH_ZERO   = 2'b11
    } sparce_cond_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_CHECK  = 3'd2,
        ST_SKIP   = 3'd3,
        ST_COOL   = 3'd4
    } sparce_seq_state_t;

    // Byte distance from the skip PC to the redirect: one slot plus the skipped ones.
    function automatic logic [7:0] skip_bytes(input logic [4:0] insts);
        return {1'b0, insts, 2'b00} + 8'd4;
    endfunction

endpackage

// File: rtl/sparce_skip_sequencer_cond_eval.sv
// Combinational SparCE skip-condition evaluator.
// Reports whether the referenced registers are settled and whether to skip.
module sparce_cond_eval
    import sparce_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  sparce_cond_t       cond,
    input  logic [REG_W-1:0]   rs1,
    input  logic [REG_W-1:0]   rs2,
    input  logic [NREGS-1:0]   srf_zero,
    input  logic [NREGS-1:0]   srf_pending,
    output logic               ready,
    output logic               take
);

    logic [REG_N-1:0] zero_x;
    logic [REG_N-1:0] pend_x;
    logic             z1;
    logic             z2;
    logic             p1;
    logic             p2;

    // x0 is hardwired zero and never has a write in flight.
    always_comb begin
        zero_x              = '0;
        pend_x              = '0;
        zero_x[NREGS-1:0]   = srf_zero;
        pend_x[NREGS-1:0]   = srf_pending;
        zero_x[0]           = 1'b1;
        pend_x[0]           = 1'b0;
    end

    assign z1 = zero_x[rs1];
    assign z2 = zero_x[rs2];
    assign p1 = pend_x[rs1];
    assign p2 = pend_x[rs2];

    always_comb begin
        ready = 1'b0;
        take  = 1'b0;
        unique case (cond)
            RS1_ZERO: begin
                ready = !p1;
                take  = z1;
            end
            RS2_ZERO: begin
                ready = !p2;
                take  = z2;
            end
            EITHER_ZERO: begin
                ready = !p1 && !p2;
                take  = z1 || z2;
            end
            BOTH_ZERO: begin
                ready = !p1 && !p2;
                take  = z1 && z2;
            end
            default: begin
                ready = 1'b0;
                take  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sparce_skip_sequencer.sv
// SparCE skip sequencer: SASA lookup, SRF settle wait, skip pulse.
// Emits a one-cycle skip with redirect target and counts issued skips.
module sparce_skip_sequencer
    import sparce_pkg::*;
#(
    parameter int PC_W     = 32,
    parameter int NREGS    = 32,
    parameter int MAX_WAIT = 4,
    parameter int COOLDOWN = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              fetch_valid,
    input  logic [PC_W-1:0]   fetch_pc,
    input  logic              pipe_stall,
    input  logic              pipe_flush,
    output logic              sasa_req,
    output logic [PC_W-1:0]   sasa_addr,
    input  logic              sasa_valid,
    input  logic              sasa_hit,
    input  logic [4:0]        sasa_rs1,
    input  logic [4:0]        sasa_rs2,
    input  logic [1:0]        sasa_cond,
    input  logic [4:0]        sasa_insts,
    input  logic [NREGS-1:0]  srf_zero,
    input  logic [NREGS-1:0]  srf_pending,
    output logic              skipping,
    output logic [PC_W-1:0]   sparce_target,
    output logic [15:0]       skip_count
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 2);
    localparam int COOL_W = $clog2(COOLDOWN + 2);

    sparce_seq_state_t state;
    sparce_seq_state_t state_d;

    logic [PC_W-1:0]   pc_q;
    logic [REG_W-1:0]  rs1_q;
    logic [REG_W-1:0]  rs2_q;
    sparce_cond_t      cond_q;
    logic [4:0]        insts_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic [COOL_W-1:0] cool_cnt;
    logic              wait_done;
    logic              cool_done;
    logic              cond_ready;
    logic              cond_take;
    logic              lookup_ok;

    sparce_cond_eval #(
        .NREGS (NREGS)
    ) u_cond (
        .cond        (cond_q),
        .rs1         (rs1_q),
        .rs2         (rs2_q),
        .srf_zero    (srf_zero),
        .srf_pending (srf_pending),
        .ready       (cond_ready),
        .take        (cond_take)
    );

    assign wait_nxt  = wait_cnt + 1'b1;
    assign wait_done = (wait_nxt >= WAIT_W'(MAX_WAIT));
    assign cool_done = (cool_cnt >= COOL_W'(COOLDOWN - 1));
    assign lookup_ok = sasa_hit && (sasa_insts != 5'd0);
    assign skipping  = (state == ST_SKIP) && !pipe_flush;

    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE: begin
                if (fetch_valid && !pipe_stall)
                    state_d = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (pipe_flush)
                    state_d = ST_IDLE;
                else if (sasa_valid)
                    state_d = lookup_ok ? ST_CHECK : ST_IDLE;
            end
            ST_CHECK: begin
                if (pipe_flush)
                    state_d = ST_IDLE;
                else if (!cond_ready)
                    state_d = wait_done ? ST_IDLE : ST_CHECK;
                else
                    state_d = cond_take ? ST_SKIP : ST_IDLE;
            end
            ST_SKIP: begin
                if (pipe_flush || COOLDOWN == 0)
                    state_d = ST_IDLE;
                else
                    state_d = ST_COOL;
            end
            ST_COOL: begin
                if (pipe_flush || cool_done)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= ST_IDLE;
            pc_q          <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            cond_q        <= RS1_ZERO;
            insts_q       <= '0;
            wait_cnt      <= '0;
            cool_cnt      <= '0;
            sasa_req      <= 1'b0;
            sasa_addr     <= '0;
            sparce_target <= '0;
            skip_count    <= '0;
        end else begin
            state    <= state_d;
            sasa_req <= (state_d == ST_LOOKUP);

            if (state == ST_IDLE && state_d == ST_LOOKUP) begin
                pc_q      <= fetch_pc;
                sasa_addr <= fetch_pc;
            end

            if (state == ST_LOOKUP && state_d == ST_CHECK) begin
                rs1_q    <= sasa_rs1;
                rs2_q    <= sasa_rs2;
                cond_q   <= sparce_cond_t'(sasa_cond);
                insts_q  <= sasa_insts;
                wait_cnt <= '0;
            end else if (state == ST_CHECK && state_d == ST_CHECK) begin
                wait_cnt <= wait_nxt;
            end

            // Target is registered on the way into SKIP so it is stable with the pulse.
            if (state_d == ST_SKIP)
                sparce_target <= pc_q + PC_W'(skip_bytes(insts_q));

            if (skipping && skip_count != 16'hFFFF)
                skip_count <= skip_count + 16'd1;

            if (state == ST_SKIP)
                cool_cnt <= '0;
            else if (state == ST_COOL)
                cool_cnt <= cool_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sparce_skip_sequencer.sv
// Directed-vector bench for sparce_skip_sequencer.
// Cycle table for the main flow plus hand sequences for corner cases.
module tb_sparce_skip_sequencer;
    import sparce_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        pipe_stall;
    logic        pipe_flush;
    logic        sasa_req;
    logic [31:0] sasa_addr;
    logic        sasa_valid;
    logic        sasa_hit;
    logic [4:0]  sasa_rs1;
    logic [4:0]  sasa_rs2;
    logic [1:0]  sasa_cond;
    logic [4:0]  sasa_insts;
    logic [31:0] srf_zero;
    logic [31:0] srf_pending;
    logic        skipping;
    logic [31:0] sparce_target;
    logic [15:0] skip_count;

    int n_chk  = 0;
    int n_fail = 0;

    sparce_skip_sequencer dut (
        .CLK           (CLK),
        .RST           (RST),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .pipe_stall    (pipe_stall),
        .pipe_flush    (pipe_flush),
        .sasa_req      (sasa_req),
        .sasa_addr     (sasa_addr),
        .sasa_valid    (sasa_valid),
        .sasa_hit      (sasa_hit),
        .sasa_rs1      (sasa_rs1),
        .sasa_rs2      (sasa_rs2),
        .sasa_cond     (sasa_cond),
        .sasa_insts    (sasa_insts),
        .srf_zero      (srf_zero),
        .srf_pending   (srf_pending),
        .skipping      (skipping),
        .sparce_target (sparce_target),
        .skip_count    (skip_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        fv;
        logic [31:0] pc;
        logic        st;
        logic        sv;
        logic        hit;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [1:0]  cond;
        logic [4:0]  ins;
        logic [31:0] zero;
        logic [31:0] pend;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_skip;
        logic [31:0] e_tgt;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic fv, input logic [31:0] pc, input logic st,
        input logic sv, input logic hit, input logic [4:0] rs1,
        input logic [4:0] rs2, input logic [1:0] cond, input logic [4:0] ins,
        input logic [31:0] zero, input logic [31:0] pend,
        input logic e_req, input logic [31:0] e_addr, input logic e_skip,
        input logic [31:0] e_tgt, input logic [15:0] e_cnt);
        vec_t v;
        v.fv = fv; v.pc = pc; v.st = st; v.sv = sv; v.hit = hit;
        v.rs1 = rs1; v.rs2 = rs2; v.cond = cond; v.ins = ins;
        v.zero = zero; v.pend = pend;
        v.e_req = e_req; v.e_addr = e_addr; v.e_skip = e_skip;
        v.e_tgt = e_tgt; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic clr();
        fetch_valid = 0; fetch_pc = 0; pipe_stall = 0; pipe_flush = 0;
        sasa_valid = 0; sasa_hit = 0; sasa_rs1 = 0; sasa_rs2 = 0;
        sasa_cond = 0; sasa_insts = 0; srf_zero = 0; srf_pending = 0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        clr();
        repeat (n) tick();
    endtask

    // Drives fetch, a zero-latency SASA hit on x5 and a settled zero x5; returns in the SKIP cycle.
    task automatic go_to_skip(input logic [31:0] pc, input logic [4:0] ins);
        clr(); fetch_valid = 1; fetch_pc = pc; tick();
        clr(); sasa_valid = 1; sasa_hit = 1; sasa_rs1 = 5;
        sasa_cond = 2'b00; sasa_insts = ins; tick();
        clr(); srf_zero = 32'h20; tick();
        clr();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clr();
        RST = 1;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_req", 32'(sasa_req), 0);
        chk("reset_addr", sasa_addr, 0);
        chk("reset_skip", 32'(skipping), 0);
        chk("reset_tgt", sparce_target, 0);
        chk("reset_cnt", 32'(skip_count), 0);
        chk("reset_state", 32'(dut.state == ST_IDLE), 1);
        RST = 0;

        // fv pc st | sv hit rs1 rs2 cond ins | zero pend | req addr skip tgt cnt
        vq.push_back(mk(1,'h100,0, 0,0,0,0,0,0, 0,0,       0,'h000,0,'h000,0));
        vq.push_back(mk(0,0,0,     1,1,5,0,0,3, 0,0,       1,'h100,0,'h000,0));
        vq.push_back(mk(0,0,0,     0,0,0,0,0,0, 'h20,0,    0,'h100,0,'h000,0));
        vq.push_back(mk(0,0,0,     0,0,0,0,0,0, 0,0,       0,'h100,1,'h110,0));
        vq.push_back(mk(1,'h200,0, 0,0,0,0,0,0, 0,0,       0,'h100,0,'h110,1));
        vq.push_back(mk(1,'h204,0, 0,0,0,0,0,0, 0,0,       0,'h100,0,'h110,1));
        vq.push_back(mk(1,'h300,0, 0,0,0,0,0,0, 0,0,       0,'h100,0,'h110,1));
        vq.push_back(mk(0,0,0,     1,0,0,0,0,0, 0,0,       1,'h300,0,'h110,1));
        vq.push_back(mk(1,'h400,0, 0,0,0,0,0,0, 0,0,       0,'h300,0,'h110,1));
        vq.push_back(mk(0,0,0,     1,1,5,6,3,1, 0,0,       1,'h400,0,'h110,1));
        vq.push_back(mk(0,0,0,     0,0,0,0,0,0, 'h20,0,    0,'h400,0,'h110,1));
        vq.push_back(mk(1,'h500,0, 0,0,0,0,0,0, 'h20,0,    0,'h400,0,'h110,1));
        vq.push_back(mk(0,0,0,     1,1,0,7,1,1, 0,0,       1,'h500,0,'h110,1));
        vq.push_back(mk(0,0,0,     0,0,0,0,0,0, 0,'h80,    0,'h500,0,'h110,1));
        vq.push_back(mk(0,0,0,     0,0,0,0,0,0, 0,'h80,    0,'h500,0,'h110,1));
        vq.push_back(mk(0,0,0,     0,0,0,0,0,0, 'h80,0,    0,'h500,0,'h110,1));
        vq.push_back(mk(0,0,0,     0,0,0,0,0,0, 0,0,       0,'h500,1,'h508,1));
        vq.push_back(mk(0,0,0,     0,0,0,0,0,0, 0,0,       0,'h500,0,'h508,2));
        vq.push_back(mk(0,0,0,     0,0,0,0,0,0, 0,0,       0,'h500,0,'h508,2));
        vq.push_back(mk(1,'h600,0, 0,0,0,0,0,0, 0,0,       0,'h500,0,'h508,2));
        vq.push_back(mk(0,0,0,     1,1,8,0,0,2, 0,0,       1,'h600,0,'h508,2));
        for (int k = 0; k < 4; k++)
            vq.push_back(mk(0,0,0, 0,0,0,0,0,0, 'h100,'h100, 0,'h600,0,'h508,2));
        vq.push_back(mk(1,'h700,0, 0,0,0,0,0,0, 'h100,'h100, 0,'h600,0,'h508,2));
        vq.push_back(mk(0,0,0,     0,0,0,0,0,0, 0,0,       1,'h700,0,'h508,2));
        vq.push_back(mk(0,0,0,     1,1,0,0,0,0, 0,0,       1,'h700,0,'h508,2));
        vq.push_back(mk(1,'h800,1, 0,0,0,0,0,0, 0,0,       0,'h700,0,'h508,2));
        vq.push_back(mk(0,0,0,     0,0,0,0,0,0, 0,0,       0,'h700,0,'h508,2));
        vq.push_back(mk(1,'h900,0, 0,0,0,0,0,0, 0,1,       0,'h700,0,'h508,2));
        vq.push_back(mk(0,0,0,     1,1,0,0,0,1, 0,1,       1,'h900,0,'h508,2));
        vq.push_back(mk(0,0,0,     0,0,0,0,0,0, 0,1,       0,'h900,0,'h508,2));
        vq.push_back(mk(0,0,0,     0,0,0,0,0,0, 0,1,       0,'h900,1,'h908,2));
        vq.push_back(mk(0,0,0,     0,0,0,0,0,0, 0,0,       0,'h900,0,'h908,3));

        for (int i = 0; i < vq.size(); i++) begin
            fetch_valid = vq[i].fv;   fetch_pc   = vq[i].pc;
            pipe_stall  = vq[i].st;   pipe_flush = 0;
            sasa_valid  = vq[i].sv;   sasa_hit   = vq[i].hit;
            sasa_rs1    = vq[i].rs1;  sasa_rs2   = vq[i].rs2;
            sasa_cond   = vq[i].cond; sasa_insts = vq[i].ins;
            srf_zero    = vq[i].zero; srf_pending = vq[i].pend;
            #1;
            chk($sformatf("v%0d_req", i), 32'(sasa_req), 32'(vq[i].e_req));
            chk($sformatf("v%0d_addr", i), sasa_addr, vq[i].e_addr);
            chk($sformatf("v%0d_skip", i), 32'(skipping), 32'(vq[i].e_skip));
            chk($sformatf("v%0d_tgt", i), sparce_target, vq[i].e_tgt);
            chk($sformatf("v%0d_cnt", i), 32'(skip_count), 32'(vq[i].e_cnt));
            tick();
        end

        // Flush during SKIP: no pulse, count held, back to IDLE.
        idle(6);
        go_to_skip(32'hA00, 5'd1);
        pipe_flush = 1;
        #1;
        chk("flush_skip_pulse", 32'(skipping), 0);
        tick();
        clr();
        #1;
        chk("flush_skip_cnt", 32'(skip_count), 3);
        chk("flush_skip_idle", 32'(dut.state == ST_IDLE), 1);

        // Flush during LOOKUP: request drops on the next cycle.
        idle(2);
        fetch_valid = 1; fetch_pc = 32'hB00; tick();
        clr(); pipe_flush = 1;
        #1;
        chk("flush_lookup_req_on", 32'(sasa_req), 1);
        tick();
        clr();
        #1;
        chk("flush_lookup_req_off", 32'(sasa_req), 0);
        chk("flush_lookup_idle", 32'(dut.state == ST_IDLE), 1);

        // Target wraps modulo 2^32.
        idle(2);
        go_to_skip(32'hFFFF_FFF8, 5'd2);
        #1;
        chk("wrap_pulse", 32'(skipping), 1);
        chk("wrap_tgt", sparce_target, 32'h0000_0004);
        tick();
        chk("wrap_cnt", 32'(skip_count), 4);

        // Counter saturation from a preloaded value.
        idle(6);
        force dut.skip_count = 16'hFFFE;
        #1;
        release dut.skip_count;
        go_to_skip(32'h1000, 5'd1);
        #1;
        chk("sat_pulse1", 32'(skipping), 1);
        tick();
        chk("sat_cnt1", 32'(skip_count), 32'hFFFF);
        idle(6);
        go_to_skip(32'h2000, 5'd1);
        #1;
        chk("sat_pulse2", 32'(skipping), 1);
        tick();
        chk("sat_cnt2", 32'(skip_count), 32'hFFFF);

        // Asynchronous reset while waiting in CHECK.
        idle(6);
        fetch_valid = 1; fetch_pc = 32'hC00; tick();
        clr(); sasa_valid = 1; sasa_hit = 1; sasa_rs1 = 9;
        sasa_cond = 2'b00; sasa_insts = 1; tick();
        clr(); srf_pending = 32'h200;
        #1;
        chk("rst_pre_check", 32'(dut.state == ST_CHECK), 1);
        #1;
        RST = 1;
        #1;
        chk("rst_mid_req", 32'(sasa_req), 0);
        chk("rst_mid_addr", sasa_addr, 0);
        chk("rst_mid_skip", 32'(skipping), 0);
        chk("rst_mid_tgt", sparce_target, 0);
        chk("rst_mid_cnt", 32'(skip_count), 0);
        chk("rst_mid_idle", 32'(dut.state == ST_IDLE), 1);
        RST = 0;
        clr();
        tick();
        fetch_valid = 1; fetch_pc = 32'hD00; tick();
        clr();
        #1;
        chk("rst_restart_req", 32'(sasa_req), 1);
        chk("rst_restart_addr", sasa_addr, 32'hD00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
